uart_recv: RTL and testbench

UART_RECV -- requirements
Module: uart_recv

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_sync2.sv | 12 +
 rtl/uart_recv.sv | 96 +++++++++
 tb/tb_uart_recv.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encodings and the default baud divisor shared with the transmitter.
package uart_pkg;
  localparam int BAUD_CNT_MAX_DEFAULT = 10416;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for a 1-bit asynchronous input, flops reset to 1.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] s_q, s_d;
  always_comb s_d = {s_q[0], d};
  always_ff @(posedge clk) s_q <= rst ? 2'b11 : s_d;
  assign q = s_q[1];
endmodule

// File: rtl/uart_recv.sv
// uart_recv: 8N1 UART receiver sampling mid-bit; define UART_RECV_PARITY_EN to add an even-parity bit.
module uart_recv
  import uart_pkg::*;
#(
  parameter int BAUD_CNT_MAX = BAUD_CNT_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       valid,
  output logic [7:0] data,
  output logic       err,
  output logic       busy
);
  localparam int CW = $clog2(BAUD_CNT_MAX + 2);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t LAST = cnt_t'(BAUD_CNT_MAX);
  localparam cnt_t HALF = cnt_t'(BAUD_CNT_MAX / 2);
  state_t state_q, state_d;
  cnt_t baud_cnt_q, baud_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, data_q, data_d;
  logic valid_q, valid_d, err_q, err_d, din_prev_q, din_prev_d;
  logic din_s, at_last, at_half, fall, par_ok;

  uart_sync2 u_sync (.clk(clk), .rst(rst), .d(din), .q(din_s));

  assign at_last = baud_cnt_q == LAST;
  assign at_half = baud_cnt_q == HALF;
  assign fall    = din_prev_q & ~din_s;

`ifdef UART_RECV_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
  logic par_q, par_d;
  always_comb par_d = (state_q == PARITY && at_last) ? din_s : par_q;
  always_ff @(posedge clk) par_q <= rst ? 1'b0 : par_d;
  assign par_ok = ~^{shift_q, par_q};
`else
  localparam state_t AFTER_DATA = STOP;
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (fall) state_d = START;
      START:  if (at_half) state_d = din_s ? IDLE : DATA;
      DATA:   if (at_last && bit_cnt_q == 3'd7) state_d = AFTER_DATA;
`ifdef UART_RECV_PARITY_EN
      PARITY: if (at_last) state_d = STOP;
`endif
      STOP:   if (at_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    baud_cnt_d = (state_q == IDLE || (state_q == START && at_half) || at_last) ? '0 : baud_cnt_q + cnt_t'(1);
    bit_cnt_d  = state_q == IDLE ? 3'd0 : (state_q == DATA && at_last) ? bit_cnt_q + 3'd1 : bit_cnt_q;
    shift_d    = shift_q;
    if (state_q == DATA && at_last) shift_d[bit_cnt_q] = din_s;
    valid_d    = state_q == STOP && at_last && din_s && par_ok;
    err_d      = state_q == STOP && at_last && !(din_s && par_ok);
    data_d     = valid_d ? shift_q : data_q;
    din_prev_d = din_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      din_prev_q <= 1'b1;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      din_prev_q <= din_prev_d;
    end
  end

  always_comb begin
    busy  = state_q != IDLE;
    valid = valid_q;
    err   = err_q;
    data  = data_q;
  end
endmodule

// File: tb/tb_uart_recv.sv
// tb_uart_recv: randomized frames against a frame-level reference model of the receiver.
module tb_uart_recv;
  localparam int BCM = 15;
  localparam int BIT = BCM + 1;
`ifdef UART_RECV_PARITY_EN
  localparam bit PB = 1'b1;
`else
  localparam bit PB = 1'b0;
`endif
  localparam int ERR_EV = 256;
  localparam int LAT = (9 + int'(PB)) * BIT + BCM / 2 + 4;

  logic clk = 1'b0, rst = 1'b1, din = 1'b1;
  logic valid, err, busy;
  logic [7:0] data;
  int cyc = 0, errors = 0, checks = 0, last_valid_cyc = 0, t0 = 0;
  int got_q[$], exp_q[$];

  uart_recv #(.BAUD_CNT_MAX(BCM)) dut (
    .clk(clk), .rst(rst), .din(din), .valid(valid), .data(data), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid && err) chk("valid_err_excl", 1, 0);
    if (valid) begin
      got_q.push_back(int'(data));
      last_valid_cyc = cyc;
    end
    if (err) got_q.push_back(ERR_EV);
  end

  task automatic drive_bit(input logic v);
    din = v;
    repeat (BIT) @(negedge clk);
  endtask

  // Model: a frame is accepted iff stop is 1 and (when enabled) data+parity has even ones.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
    if (stop && (!PB || ^{b, par} == 1'b0)) exp_q.push_back(int'(b));
    else exp_q.push_back(ERR_EV);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PB) drive_bit(par);
    drive_bit(stop);
    din = 1'b1;
  endtask

  task automatic idle(input int n);
    din = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic compare(input string tag);
    int n;
    idle(40);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = got_q.size() < exp_q.size() ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk(tag, got_q[i], exp_q[i]);
    chk({tag, "_busy"}, busy, 0);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", data, 0);

    t0 = cyc;
    send_frame(8'h55, 1'b1, ^8'h55);
    compare("f55");
    chk("f55_data", data, 8'h55);
    chk("f55_latency_ok", (last_valid_cyc - t0 >= LAT - 2) && (last_valid_cyc - t0 <= LAT + 2), 1);

    din = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch_busy", busy, 1);
    @(negedge clk);
    din = 1'b1;
    repeat (12) @(negedge clk);
    chk("glitch_idle", busy, 0);
    compare("glitch");

    send_frame(8'h3C, 1'b1, ^8'h3C);
    idle(4);
    send_frame(8'hA5, 1'b0, ^8'hA5);
    compare("badstop");
    chk("badstop_data", data, 8'h3C);

    send_frame(8'hA5, 1'b1, ^8'hA5);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    compare("b2b");
    chk("b2b_data", data, 8'h3C);

    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    din = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (BIT * 6) @(negedge clk);
    chk("abort_data", data, 0);
    chk("abort_busy", busy, 0);
    send_frame(8'h81, 1'b1, ^8'h81);
    compare("abort");
    chk("abort_new_data", data, 8'h81);

    if (PB) begin
      send_frame(8'h07, 1'b1, 1'b1);
      idle(4);
      send_frame(8'h07, 1'b1, 1'b0);
      compare("parity");
    end

    for (int k = 0; k < 24; k++) begin
      logic [7:0] b;
      logic stop, par;
      b = 8'($urandom);
      stop = $urandom_range(7) != 0;
      par = ^b ^ (PB && $urandom_range(3) == 0);
      send_frame(b, stop, par);
      idle(stop ? $urandom_range(0, 8) : $urandom_range(2, 8));
    end
    compare("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
